// File: rtl/seq_tx_101.sv
// seq_tx_101: serial pattern transmitter for the "101" detector family.
// Shifts a held WIDTH-bit word out MSB-first Repeat+1 times. A one-cycle gap
// separates the words. It also counts the overlapping "101" matches that it
// has emitted on valid bits.
module seq_tx_101 #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data,
    input  logic [REP_W-1:0] Repeat,
    output logic             Dout,
    output logic             Valid,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Count101
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    // The state register always names the phase that the output registers
    // currently show. The next-state logic therefore also decides the next
    // output values.
    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [REP_W-1:0] rep, rep_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [1:0]       hist, hist_n, hist_b;
    logic [CNT_W-1:0] cnt_n, cnt_b;
    logic             bit_n;

    // Next-state logic. Word sequencing and the "101" tracker for the bit that
    // goes out next.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        rep_n   = rep;
        hold_n  = hold;
        sh_n    = sh;
        hist_b  = hist;
        cnt_b   = Count101;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (Load) begin
                    state_n = SHIFT;
                    idx_n   = '0;
                    hold_n  = Data;
                    sh_n    = Data;
                    rep_n   = Repeat;
                    hist_b  = '0;
                    cnt_b   = '0;
                end
            end
            SHIFT: begin
                if (idx == LAST) begin
                    if (rep != '0) begin
                        rep_n   = rep - 1'b1;
                        state_n = GAP;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    idx_n = idx + 1'b1;
                    sh_n  = {sh[WIDTH-2:0], 1'b0};
                end
            end
            GAP: begin
                // Send the held word again from its MSB.
                state_n = SHIFT;
                idx_n   = '0;
                sh_n    = hold;
            end
            default: state_n = IDLE;
        endcase

        bit_n  = sh_n[WIDTH-1];
        hist_n = hist_b;
        cnt_n  = cnt_b;
        // Only payload bits move the history. The gap cycle leaves it intact,
        // so a match can span two words.
        if (state_n == SHIFT) begin
            hist_n = {hist_b[0], bit_n};
            if (hist_b == 2'b10 && bit_n && cnt_b != CMAX)
                cnt_n = cnt_b + 1'b1;
        end
    end

    // State, datapath and registered outputs. Reset aborts a transfer at once.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            idx      <= '0;
            rep      <= '0;
            hold     <= '0;
            sh       <= '0;
            hist     <= '0;
            Count101 <= '0;
            Dout     <= 1'b0;
            Valid    <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            rep      <= rep_n;
            hold     <= hold_n;
            sh       <= sh_n;
            hist     <= hist_n;
            Count101 <= cnt_n;
            Dout     <= (state_n == SHIFT) & bit_n;
            Valid    <= (state_n == SHIFT);
            Busy     <= (state_n == SHIFT) || (state_n == GAP);
            Done     <= (state_n == DONE);
        end
    end
endmodule

// File: tb/tb_seq_tx_101.sv
// Testbench for seq_tx_101. A reference model predicts every cycle of each
// transfer: the word index, the bit position and the gap slot, plus a running
// "101" count over the payload bit list. A second instance with a 4-bit
// counter checks saturation.
module tb_seq_tx_101;
    logic       Clk = 1'b0;
    logic       Rst;
    logic       Load;
    logic [7:0] Data;
    logic [3:0] Repeat;
    logic       Dout, Valid, Busy, Done;
    logic [7:0] Count101;
    logic       s_dout, s_valid, s_busy, s_done;
    logic [3:0] s_count;

    int nchk  = 0;
    int npass = 0;

    bit q[$];
    int mcnt;

    seq_tx_101 dut (
        .Clk(Clk), .Rst(Rst), .Load(Load), .Data(Data), .Repeat(Repeat),
        .Dout(Dout), .Valid(Valid), .Busy(Busy), .Done(Done), .Count101(Count101)
    );

    seq_tx_101 #(.WIDTH(8), .REP_W(4), .CNT_W(4)) sat (
        .Clk(Clk), .Rst(Rst), .Load(Load), .Data(Data), .Repeat(Repeat),
        .Dout(s_dout), .Valid(s_valid), .Busy(s_busy), .Done(s_done), .Count101(s_count)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        q.delete();
        mcnt = 0;
    endtask

    task automatic model_push(input bit b);
        int n;
        q.push_back(b);
        n = q.size();
        if (n >= 3 && q[n-3] && !q[n-2] && q[n-1]) mcnt++;
    endtask

    task automatic chk_cyc(input string tag, input bit d, input bit v, input bit b, input bit dn);
        chk({tag, ".dout"}, 32'(Dout), 32'(d));
        chk({tag, ".valid"}, 32'(Valid), 32'(v));
        chk({tag, ".busy"}, 32'(Busy), 32'(b));
        chk({tag, ".done"}, 32'(Done), 32'(dn));
        chk({tag, ".cnt"}, 32'(Count101), 32'(mcnt > 255 ? 255 : mcnt));
        chk({tag, ".satcnt"}, 32'(s_count), 32'(mcnt > 15 ? 15 : mcnt));
    endtask

    // One full transfer. inj >= 0 pulses Load with other data during that cycle.
    // If chain is set, the task returns in the Done cycle without ticking, so
    // that the next call loads back-to-back.
    task automatic xfer(input string tag, input logic [7:0] d, input int rep,
                        input int inj, input bit chain);
        int total;
        int p;
        Load = 1'b1; Data = d; Repeat = 4'(rep);
        model_clear();
        tick();
        Load = 1'b0; Data = 8'($urandom); Repeat = 4'($urandom);
        total = (rep + 1) * 8 + rep + 1;
        for (int k = 0; k < total; k++) begin
            p = k % 9;
            if (k == total - 1) chk_cyc({tag, ".done"}, 0, 0, 0, 1);
            else if (p == 8)    chk_cyc({tag, ".gap"}, 0, 0, 1, 0);
            else begin
                model_push(d[7-p]);
                chk_cyc({tag, ".bit"}, d[7-p], 1, 1, 0);
            end
            if (k == total - 1) begin
                if (!chain) begin
                    tick();
                    chk_cyc({tag, ".idle"}, 0, 0, 0, 0);
                end
            end else begin
                Load = (k == inj);
                if (k == inj) Data = ~d;
                tick();
                Load = 1'b0;
            end
        end
    endtask

    initial begin
        Rst = 1'b0; Load = 1'b0; Data = '0; Repeat = '0;
        model_clear();
        #12;
        chk_cyc("reset", 0, 0, 0, 0);
        Rst = 1'b1;
        tick();
        chk_cyc("idle0", 0, 0, 0, 0);

        xfer("a5", 8'b10100101, 0, -1, 0);
        chk("a5.total", 32'(Count101), 32'd2);
        xfer("55r1", 8'h55, 1, -1, 0);
        chk("55r1.total", 32'(Count101), 32'd7);
        xfer("55r15", 8'h55, 15, -1, 0);
        chk("55r15.total", 32'(Count101), 32'd63);
        chk("55r15.sat", 32'(s_count), 32'd15);
        xfer("inj", 8'hC5, 0, 4, 0);

        // Reset between edges in payload cycle 5. Outputs must drop at once.
        Load = 1'b1; Data = 8'hA5; Repeat = 4'd2;
        tick();
        Load = 1'b0;
        repeat (4) tick();
        #2 Rst = 1'b0;
        #1;
        model_clear();
        chk_cyc("midrst", 0, 0, 0, 0);
        #1 Rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_cyc("postrst", 0, 0, 0, 0);
        end

        // Load held during Done starts the next transfer with a cleared count.
        xfer("chain1", 8'h3B, 0, -1, 1);
        xfer("chain2", 8'hA0, 0, -1, 0);

        for (int r = 0; r < 20; r++) begin
            int inj;
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            xfer("rnd", 8'($urandom), int'($urandom_range(0, 3)), inj,
                 1'($urandom_range(0, 1)));
        end
        tick();
        chk_cyc("final", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/seq_tx_101.md
Name: seq_tx_101

Overview:
- Serial pattern transmitter that drives test streams into the team's serial sequence detectors (the "101" Moore detector family).
- Accepts a WIDTH-bit word plus a repeat count, then shifts the word out MSB-first, one bit per clock, with a qualifying Valid strobe.
- Keeps a running count of overlapping "101" occurrences it emitted, so the detector's Q pulses can be checked against a known reference count.

Parameters:
- WIDTH, 8, bits per word; must be >= 3.
- REP_W, 4, width of Repeat; number of words sent = Repeat+1 (1..16 at default).
- CNT_W, 8, width of Count101; saturating.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Rst  input  1  reset, asynchronous, active-low.
- Load  input  1  start request; sampled on rising Clk.
- Data  input  WIDTH  word to transmit; captured when Load is accepted.
- Repeat  input  REP_W  extra repetitions; captured when Load is accepted.
- Dout  output  1  serial data bit, registered.
- Valid  output  1  high when Dout carries a payload bit.
- Busy  output  1  high from the first payload cycle through the last payload or gap cycle.
- Done  output  1  one-cycle pulse after the final bit.
- Count101  output  CNT_W  overlapping "101" count over the current/last transfer.

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE; Dout=0, Valid=0, Busy=0, Done=0, Count101=0; bit index, repeat counter and 2-bit history cleared. Reset asserted mid-transfer aborts the transfer immediately, with no Done.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE or DONE, Load=1: capture Data into a hold register and Repeat into the repeat counter. Clear Count101 and history. Go to SHIFT.
  - Latency: first bit (Data[WIDTH-1]) appears on Dout with Valid=1 in the cycle after the Load edge.
- Load while in SHIFT or GAP: ignored, with no effect on the transfer.
- SHIFT:
  - Each cycle Dout=hold[WIDTH-1-idx], Valid=1, Busy=1.
  - idx counts 0..WIDTH-1.
  - After idx=WIDTH-1: if repeat counter != 0, decrement it and go to GAP; else go to DONE.
- GAP: exactly one cycle with Dout=0, Valid=0, Busy=1. Then SHIFT with idx=0, retransmitting the same held word.
- DONE: one cycle with Done=1, Busy=0, Valid=0, Dout=0. Next state is IDLE, or SHIFT if Load=1 (back-to-back transfer allowed).
- IDLE: Dout=0, Valid=0, Busy=0, Done=0; Count101 holds its last value.
- Count101 tracker:
  - Samples only Valid bits, using a 2-bit history of the previous Valid bits.
  - Increments when the previous two Valid bits were 1,0 and the current Valid bit is 1 (overlapping matches count).
  - History persists across GAP, so a match may span words; GAP bits are not sampled.
  - The counter is registered and includes the final bit by the cycle Done=1.
  - Saturates at 2^CNT_W-1; no wrap.
- Data/Repeat changes outside the Load-accept edge have no effect.

Test Plan:
- Reset, then Load with Data=8'b10100101, Repeat=0 -> Dout=1,0,1,0,0,1,0,1 on cycles 1..8 with Valid=1 and Busy=1; Done=1 on cycle 9; Count101=2; IDLE after.
- Data=8'h55, Repeat=1 -> 8 bits 01010101, one GAP cycle (Valid=0, Dout=0, Busy=1), 8 bits 01010101, then Done. Count101=7 (3+3+1, the cross-boundary match counted).
- Data=8'h55, Repeat=15 -> 16 words with 15 gaps, 143 Busy cycles, then Done; Count101=63.
- Pulse Load again at payload cycle 4 with different Data -> ignored; the original stream completes unchanged and Count101 matches the original word.
- Drive Rst=0 mid-SHIFT (cycle 5, between clock edges) -> Dout, Valid, Busy, Done and Count101 go to 0 immediately. After Rst=1, no Done is seen and the block sits in IDLE until a new Load.
- Hold Load=1 during the Done cycle with Data=8'hA0 -> next cycle starts a new transfer (Dout=1, Valid=1) and Count101 is cleared. Also connect Dout to the 101 detector's Din: its Q pulse count equals Count101 for single-word transfers.
